tl_flow_scheduler: RTL and testbench

Sequencing and flow-control controller for the transaction-layer datapath. It drains the input FIFO, routes each word to one of four output FIFOs (P0..P3) by destination field, and stalls per destination on almost-full. It also owns the Umbral_bajo/Umbral_alto threshold configuration during the init phase and the per-port delivered-word counters read through req/idx.

---
 rtl/tl_pkg.sv | 20 ++
 rtl/tl_flow_scheduler_counter.sv | 27 ++
 rtl/tl_flow_scheduler.sv | 131 +++++++++++++
 tb/tb_tl_flow_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// tl_pkg: shared definitions for the transaction-layer flow scheduler.
//   - state_t    : FSM encoding exposed on the scheduler's state port
//   - NUM_PORTS  : number of output FIFOs (P0..P3)
//   - DEST_W     : width of the destination field (top bits of a data word)
//   - DEF_BAJO / DEF_ALTO : threshold values loaded on reset
package tl_pkg;

    localparam int NUM_PORTS = 4;
    localparam int DEST_W    = 2;
    localparam int DEF_BAJO  = 1;
    localparam int DEF_ALTO  = 6;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

endpackage

// File: rtl/tl_flow_scheduler_counter.sv
// tl_port_counter: saturating delivered-word counter for one output port.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (held during configuration)
//   inc      : count one delivered word
//   count    : current value, sticks at all-ones
module tl_port_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/tl_flow_scheduler.sv
// tl_flow_scheduler: drains the input FIFO through a one-entry stage and
// routes each word to output FIFO P0..P3 selected by its top DEST_W bits,
// stalling per destination on almost-full. Owns the threshold configuration
// during INIT and the per-port delivered-word counters.
// Ports:
//   clk, reset                       : clock, asynchronous active-high reset
//   init                             : configuration phase request
//   Umbral_bajo_in / Umbral_alto_in  : threshold candidates (taken if bajo < alto)
//   in_empty, in_data, in_pop        : input FIFO (first-word-fall-through)
//   out_almost_full, out_push, out_data : output FIFOs, push is one-hot or zero
//   Umbral_bajo / Umbral_alto        : active thresholds
//   req, idx, counterOut, counterValid : counter read port (serviced in IDLE)
//   state                            : FSM state (RESET/INIT/IDLE/ACTIVE)
//
// Handshake: a word moves from the input FIFO when in_pop=1 (in_pop is only
// raised with in_empty=0); a word is handed to port d when out_push[d]=1, which
// is only issued for a decision taken while out_almost_full[d]=0.
module tl_flow_scheduler
    import tl_pkg::*;
#(
    parameter int DATA_W   = 12,
    parameter int UMB_W    = 3,
    parameter int CNT_W    = 5,
    parameter int DEF_BAJO = tl_pkg::DEF_BAJO,
    parameter int DEF_ALTO = tl_pkg::DEF_ALTO
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [UMB_W-1:0]     Umbral_bajo_in,
    input  logic [UMB_W-1:0]     Umbral_alto_in,
    input  logic                 in_empty,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 in_pop,
    input  logic [NUM_PORTS-1:0] out_almost_full,
    output logic [NUM_PORTS-1:0] out_push,
    output logic [DATA_W-1:0]    out_data,
    output logic [UMB_W-1:0]     Umbral_bajo,
    output logic [UMB_W-1:0]     Umbral_alto,
    input  logic                 req,
    input  logic [1:0]           idx,
    output logic [CNT_W-1:0]     counterOut,
    output logic                 counterValid,
    output logic [1:0]           state
);

    state_t              st;
    logic                stage_valid;
    logic [DATA_W-1:0]   stage_data;
    logic [DEST_W-1:0]   dest;
    logic                drain;
    logic [NUM_PORTS-1:0] push_vec;
    logic [CNT_W-1:0]    cnt [NUM_PORTS];

    assign state = st;
    assign dest  = stage_data[DATA_W-1 -: DEST_W];

    // The stage leaves this cycle if its destination can take a word.
    assign drain    = stage_valid && !out_almost_full[dest];
    assign push_vec = drain ? (NUM_PORTS'(1) << dest) : '0;

    // A pop refills the stage on the same edge it drains, giving one word per
    // cycle; a pending init stops new pops so the stage can empty out.
    assign in_pop = (st == ST_ACTIVE) && !in_empty && (!stage_valid || drain) && !init;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st           <= ST_RESET;
            stage_valid  <= 1'b0;
            stage_data   <= '0;
            out_push     <= '0;
            out_data     <= '0;
            Umbral_bajo  <= UMB_W'(DEF_BAJO);
            Umbral_alto  <= UMB_W'(DEF_ALTO);
            counterOut   <= '0;
            counterValid <= 1'b0;
        end else begin
            out_push <= push_vec;
            if (drain) begin
                out_data <= stage_data;
            end

            if (in_pop) begin
                stage_data  <= in_data;
                stage_valid <= 1'b1;
            end else if (drain) begin
                stage_valid <= 1'b0;
            end

            // Inconsistent threshold pairs are ignored so the FIFOs never see
            // a low threshold at or above the high one.
            if ((st == ST_INIT) && (Umbral_bajo_in < Umbral_alto_in)) begin
                Umbral_bajo <= Umbral_bajo_in;
                Umbral_alto <= Umbral_alto_in;
            end

            counterValid <= req && (st == ST_IDLE);
            if (req && (st == ST_IDLE)) begin
                counterOut <= cnt[idx];
            end

            case (st)
                ST_RESET:  st <= ST_INIT;
                ST_INIT:   if (!init) st <= ST_IDLE;
                ST_IDLE: begin
                    if (init)           st <= ST_INIT;
                    else if (!in_empty) st <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (init) begin
                        if (!stage_valid) st <= ST_INIT;
                    end else if (in_empty && !stage_valid) begin
                        st <= ST_IDLE;
                    end
                end
                default:   st <= ST_RESET;
            endcase
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_cnt
        tl_port_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst   (reset),
            .clr   (st == ST_INIT),
            .inc   (out_push[p]),
            .count (cnt[p])
        );
    end

endmodule

// File: tb/tb_tl_flow_scheduler.sv
// Testbench for tl_flow_scheduler: directed scenarios plus a randomized burst,
// checked against a scoreboard of popped words and per-port delivery counts.
module tb_tl_flow_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        init;
    logic [2:0]  Umbral_bajo_in;
    logic [2:0]  Umbral_alto_in;
    logic        in_empty;
    logic [11:0] in_data;
    logic        in_pop;
    logic [3:0]  out_almost_full;
    logic [3:0]  out_push;
    logic [11:0] out_data;
    logic [2:0]  Umbral_bajo;
    logic [2:0]  Umbral_alto;
    logic        req;
    logic [1:0]  idx;
    logic [4:0]  counterOut;
    logic        counterValid;
    logic [1:0]  state;

    tl_flow_scheduler dut (
        .clk             (clk),
        .reset           (reset),
        .init            (init),
        .Umbral_bajo_in  (Umbral_bajo_in),
        .Umbral_alto_in  (Umbral_alto_in),
        .in_empty        (in_empty),
        .in_data         (in_data),
        .in_pop          (in_pop),
        .out_almost_full (out_almost_full),
        .out_push        (out_push),
        .out_data        (out_data),
        .Umbral_bajo     (Umbral_bajo),
        .Umbral_alto     (Umbral_alto),
        .req             (req),
        .idx             (idx),
        .counterOut      (counterOut),
        .counterValid    (counterValid),
        .state           (state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / model ----------------
    int          vectors    = 0;
    int          miscompares = 0;
    logic [11:0] src_q[$];     // words waiting in the modelled input FIFO
    logic [11:0] exp_q[$];     // words popped, awaiting delivery in order
    int          cnt_m[4];     // expected delivered-word counters
    int          ub_m, ua_m;   // expected thresholds
    int          cyc = 0;
    int          push_cnt = 0;
    int          first_push_cyc = 0;
    int          last_push_cyc = 0;
    logic        last_pop;
    logic [3:0]  af_prev;
    logic [1:0]  st_pre;
    logic [2:0]  ub_pre, ua_pre;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_src();
        in_empty = (src_q.size() == 0);
        in_data  = in_empty ? 12'h000 : src_q[0];
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) cnt_m[i] = 0;
        ub_m = 1;
        ua_m = 6;
    endtask

    // One clock: sample the pre-edge view on the falling edge, then update the
    // model and check registered outputs just after the rising edge.
    task automatic cycle();
        logic [11:0] w;
        logic [3:0]  one;
        int          d;
        @(negedge clk);
        last_pop = in_pop;
        af_prev  = out_almost_full;
        st_pre   = state;
        ub_pre   = Umbral_bajo_in;
        ua_pre   = Umbral_alto_in;
        if (last_pop) check("pop_nonempty", 32'(in_empty), 0);
        @(posedge clk);
        #1;
        cyc++;
        if (st_pre == 2'd1) begin
            for (int i = 0; i < 4; i++) cnt_m[i] = 0;
            if (ub_pre < ua_pre) begin
                ub_m = int'(ub_pre);
                ua_m = int'(ua_pre);
            end
        end
        if (last_pop) exp_q.push_back(src_q.pop_front());
        drive_src();
        check("umbral", {26'd0, Umbral_alto, Umbral_bajo}, 32'((ua_m << 3) | ub_m));
        if (out_push != 4'd0) begin
            push_cnt++;
            if (push_cnt == 1) first_push_cyc = cyc;
            last_push_cyc = cyc;
            check("push_onehot", 32'($countones(out_push)), 1);
            check("push_while_af", 32'(out_push & af_prev), 0);
            if (exp_q.size() == 0) begin
                check("push_unexpected", 32'(out_push), 0);
            end else begin
                w   = exp_q.pop_front();
                d   = int'(w[11:10]);
                one = 4'b0001;
                check("push_port", 32'(out_push), 32'(one << d));
                check("push_data", 32'(out_data), 32'(w));
                if (cnt_m[d] < 31) cnt_m[d]++;
            end
        end
    endtask

    task automatic wait_state(input string tag, input logic [1:0] s, input int budget);
        int n = 0;
        while (state !== s && n < budget) begin
            cycle();
            n++;
        end
        check(tag, 32'(state), 32'(s));
    endtask

    task automatic wait_pushes(input string tag, input int target, input int budget);
        int n = 0;
        while (push_cnt < target && n < budget) begin
            cycle();
            n++;
        end
        check(tag, push_cnt, target);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (!(src_q.size() == 0 && exp_q.size() == 0 && state == 2'd2) && n < budget) begin
            cycle();
            n++;
        end
        check(tag, 32'(src_q.size() + exp_q.size()), 0);
        check({tag, "_idle"}, 32'(state), 2);
    endtask

    task automatic read_cnt(input logic [1:0] i, input int exp);
        req = 1'b1;
        idx = i;
        cycle();
        check("cnt_valid", 32'(counterValid), 1);
        check("cnt_value", 32'(counterOut), 32'(exp));
        req = 1'b0;
        cycle();
        check("cnt_valid_drop", 32'(counterValid), 0);
        check("cnt_hold", 32'(counterOut), 32'(exp));
    endtask

    task automatic add_word(input logic [1:0] d, input logic [9:0] payload);
        src_q.push_back({d, payload});
        drive_src();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int start;
        reset = 1'b1;
        init  = 1'b1;
        Umbral_bajo_in  = 3'd0;
        Umbral_alto_in  = 3'd0;
        out_almost_full = 4'd0;
        req = 1'b0;
        idx = 2'd0;
        drive_src();
        model_reset();

        // 1. reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 0);
        check("rst_pop", 32'(in_pop), 0);
        check("rst_push", 32'(out_push), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_cnt", 32'(counterOut), 0);
        check("rst_cval", 32'(counterValid), 0);
        check("rst_bajo", 32'(Umbral_bajo), 1);
        check("rst_alto", 32'(Umbral_alto), 6);
        reset = 1'b0;
        cycle();
        check("init_state", 32'(state), 1);

        // 2. configuration (values written as alto/bajo)
        Umbral_alto_in = 3'd5; Umbral_bajo_in = 3'd1; cycle();
        Umbral_alto_in = 3'd6; Umbral_bajo_in = 3'd0; cycle();
        Umbral_alto_in = 3'd2; Umbral_bajo_in = 3'd4; cycle();
        init = 1'b0;
        cycle();
        check("cfg_alto", 32'(Umbral_alto), 6);
        check("cfg_bajo", 32'(Umbral_bajo), 0);
        check("cfg_idle", 32'(state), 2);

        // 3. routing and throughput
        push_cnt = 0;
        start = cyc;
        add_word(2'd0, 10'h001);
        add_word(2'd1, 10'h002);
        add_word(2'd2, 10'h003);
        add_word(2'd3, 10'h004);
        wait_pushes("route_pushes", 4, 20);
        check("route_latency", 32'(first_push_cyc - start), 3);
        check("route_rate", 32'(last_push_cyc - first_push_cyc), 3);
        drain("route_drain", 20);
        read_cnt(2'd2, 1);

        // 4. stall on P0
        push_cnt = 0;
        for (int k = 1; k <= 7; k++) add_word(2'd0, 10'(k));
        wait_pushes("stall_first5", 5, 30);
        out_almost_full = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("stall_no_pop", 32'(last_pop), 0);
        end
        check("stall_pushes", push_cnt, 5);
        check("stall_src_left", 32'(src_q.size()), 1);
        out_almost_full = 4'b0000;
        wait_pushes("stall_resume", 7, 20);
        drain("stall_drain", 20);
        read_cnt(2'd0, 8);

        // 5. saturation, then reset mid-burst
        push_cnt = 0;
        for (int k = 0; k < 40; k++) add_word(2'd3, 10'(k));
        wait_pushes("sat_pushes", 40, 100);
        drain("sat_drain", 20);
        read_cnt(2'd3, 31);
        push_cnt = 0;
        for (int k = 0; k < 10; k++) add_word(2'd3, 10'(k + 100));
        wait_pushes("burst_start", 3, 20);
        reset = 1'b1;
        init  = 1'b1;
        #1;
        check("midrst_push", 32'(out_push), 0);
        check("midrst_state", 32'(state), 0);
        check("midrst_pop", 32'(in_pop), 0);
        src_q.delete();
        exp_q.delete();
        drive_src();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        wait_state("reinit", 2'd1, 5);
        init = 1'b0;
        wait_state("reinit_idle", 2'd2, 5);
        read_cnt(2'd3, 0);

        // 6. init during ACTIVE with a stalled stage
        out_almost_full = 4'b0010;
        add_word(2'd1, 10'h0AA);
        add_word(2'd1, 10'h0BB);
        wait_state("hol_active", 2'd3, 5);
        cycle();
        cycle();
        init = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("hol_no_pop", 32'(last_pop), 0);
            check("hol_stay", 32'(state), 3);
        end
        push_cnt = 0;
        out_almost_full = 4'b0000;
        wait_state("hol_to_init", 2'd1, 10);
        check("hol_one_push", push_cnt, 1);
        check("hol_src_left", 32'(src_q.size()), 1);
        init = 1'b0;
        drain("hol_drain", 20);

        // 7. randomized thresholds and traffic
        init = 1'b1;
        wait_state("rnd_init", 2'd1, 5);
        for (int k = 0; k < 8; k++) begin
            Umbral_alto_in = 3'($urandom_range(0, 7));
            Umbral_bajo_in = 3'($urandom_range(0, 7));
            cycle();
        end
        init = 1'b0;
        wait_state("rnd_idle", 2'd2, 5);
        begin
            int words_left = 60;
            for (int k = 0; k < 400; k++) begin
                if (words_left > 0 && $urandom_range(0, 3) != 0) begin
                    add_word(2'($urandom_range(0, 3)), 10'($urandom_range(0, 1023)));
                    words_left--;
                end
                for (int p = 0; p < 4; p++) out_almost_full[p] = ($urandom_range(0, 3) == 0);
                cycle();
            end
        end
        out_almost_full = 4'b0000;
        drain("rnd_drain", 200);
        for (int p = 0; p < 4; p++) read_cnt(2'(p), cnt_m[p]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
